// File: rtl/kapilan_alarm_pkg.sv
// kapilan_alarm_pkg: shared constants for the kapilan_alarm 24-hour clock tile.
//   - Field limits and widths for the seconds, minutes and hours counters.
//   - The constant bidirectional-pin output-enable pattern.
//   - A helper that compares the current time against the alarm setting.
package kapilan_alarm_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  // uio[7:3] carry the hours out; uio[2:0] are inputs for the alarm minutes.
  localparam logic [7:0] UIO_OE_VAL = 8'b1111_1000;

  // Out-of-range alarm settings can never equal a counter value, so they
  // never fire without any extra range check.
  function automatic logic time_match(
    input logic [HR_W-1:0]  hr,
    input logic [MIN_W-1:0] mn,
    input logic [HR_W-1:0]  alarm_hr,
    input logic [MIN_W-1:0] alarm_mn
  );
    return (hr == alarm_hr) && (mn == alarm_mn);
  endfunction

endpackage

// File: rtl/kapilan_alarm_counter.sv
// mod_counter: wrap-around binary counter 0..MAX with carry-out.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : advance by one on this edge
//   count : current value
//   carry : inc && count==MAX, i.e. this edge wraps the counter to 0
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count and carry-out.
  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (inc) begin
      if (count_q == MAX_V) begin
        count_d = '0;
        carry   = 1'b1;
      end else begin
        count_d = count_q + ONE_V;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/kapilan_alarm.sv
// kapilan_alarm: Tiny Tapeout tile, 24-hour hh:mm:ss clock with one alarm.
//   clk, rst_n : tile clock, asynchronous active-low reset
//   ena        : when low, the prescaler and time counters hold
//   ui_in      : [4:0] alarm hours, [7:5] alarm minutes[2:0]
//   uio_in     : [2:0] alarm minutes[5:3], [7:3] unused
//   uo_out     : [5:0] minutes, [6] alarm active, [7] seconds[0]
//   uio_out    : [2:0] zero, [7:3] hours
//   uio_oe     : constant 8'b1111_1000
module kapilan_alarm
  import kapilan_alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0]  ps_d;
  logic [PS_W-1:0]  ps_q;
  logic             tick_s;
  logic             sec_carry_s;
  logic             min_carry_s;
  logic             hr_carry_s;
  logic [SEC_W-1:0] sec_s;
  logic [MIN_W-1:0] min_s;
  logic [HR_W-1:0]  hr_s;
  logic [HR_W-1:0]  alarm_hr_s;
  logic [MIN_W-1:0] alarm_min_s;
  logic             alarm_d;
  logic             alarm_q;
  logic             unused_uio_s;

  // Prescaler: tick_s pulses on the edge where the count wraps.
  always_comb begin
    ps_d   = ps_q;
    tick_s = 1'b0;
    if (ena) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        tick_s = 1'b1;
      end else begin
        ps_d = ps_q + PS_ONE;
      end
    end else begin
      ps_d = ps_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // Ripple of carries: all three fields can wrap on the same edge.
  mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(tick_s), .count(sec_s), .carry(sec_carry_s)
  );
  mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(sec_carry_s), .count(min_s), .carry(min_carry_s)
  );
  mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(min_carry_s), .count(hr_s), .carry(hr_carry_s)
  );

  assign alarm_hr_s   = ui_in[4:0];
  assign alarm_min_s  = {uio_in[2:0], ui_in[7:5]};
  assign unused_uio_s = ^{uio_in[7:3], hr_carry_s};

  // Alarm compare runs regardless of ena; inputs are not latched.
  always_comb begin
    alarm_d = time_match(hr_s, min_s, alarm_hr_s, alarm_min_s);
  end

  // Alarm flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign uo_out  = {sec_s[0], alarm_q, min_s};
  assign uio_out = {hr_s, 3'b000};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_kapilan_alarm.sv
// tb_kapilan_alarm: scoreboard bench. Four tiles share one clock:
//   dut0 TICKS=2 alarm 00:00 (reset, blink, minute and hour carry, alarm at start)
//   dut1 TICKS=1 alarm 00:01 (alarm window, day wrap)
//   dut2 TICKS=1 alarm 24:60 (must never fire over a full day)
//   dut3 TICKS=1 alarm 01:00 (ena hold at 00:00:05, asynchronous reset)
// Expected values are queued per tile, tagged with the cycle count after
// reset release; a monitor pops and compares them on the falling edge, or
// on an explicit event for checks that must happen between clock edges.
module tb_kapilan_alarm;

  typedef struct {
    int         cyc;
    bit         asy;
    logic [7:0] m_uo;
    logic [7:0] e_uo;
    logic [7:0] m_uio;
    logic [7:0] e_uio;
    logic [7:0] m_oe;
    logic [7:0] e_oe;
    string      name;
  } exp_t;

  localparam int LAST_CYC = 86402;

  exp_t sbq[4][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   run    = 1'b0;
  event async_ev;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_d;
  logic ena_on;
  logic ena_d;
  logic [3:0][7:0] ui;
  logic [3:0][7:0] uio_i;
  logic [3:0][7:0] uo;
  logic [3:0][7:0] uio_o;
  logic [3:0][7:0] oe;

  always #5 clk = ~clk;

  kapilan_alarm #(.TICKS_PER_SEC(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena_on), .ui_in(ui[0]), .uio_in(uio_i[0]),
    .uo_out(uo[0]), .uio_out(uio_o[0]), .uio_oe(oe[0]));
  kapilan_alarm #(.TICKS_PER_SEC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena_on), .ui_in(ui[1]), .uio_in(uio_i[1]),
    .uo_out(uo[1]), .uio_out(uio_o[1]), .uio_oe(oe[1]));
  kapilan_alarm #(.TICKS_PER_SEC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena_on), .ui_in(ui[2]), .uio_in(uio_i[2]),
    .uo_out(uo[2]), .uio_out(uio_o[2]), .uio_oe(oe[2]));
  kapilan_alarm #(.TICKS_PER_SEC(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n_d), .ena(ena_d), .ui_in(ui[3]), .uio_in(uio_i[3]),
    .uo_out(uo[3]), .uio_out(uio_o[3]), .uio_oe(oe[3]));

  task automatic push(input int k, input int c, input bit a,
                      input logic [7:0] muo, input logic [7:0] euo,
                      input logic [7:0] muio, input logic [7:0] euio,
                      input logic [7:0] moe, input logic [7:0] eoe,
                      input string n);
    exp_t e;
    e.cyc = c; e.asy = a;
    e.m_uo = muo; e.e_uo = euo;
    e.m_uio = muio; e.e_uio = euio;
    e.m_oe = moe; e.e_oe = eoe;
    e.name = n;
    sbq[k].push_back(e);
  endtask

  task automatic check_front(input int k, input bit asy);
    exp_t e;
    while (sbq[k].size() > 0) begin
      e = sbq[k][0];
      if (e.asy != asy) break;
      if (!asy && e.cyc > cyc) break;
      void'(sbq[k].pop_front());
      checks++;
      if (!asy && e.cyc < cyc) begin
        errors++;
        $display("FAIL %s dut%0d: expectation for cycle %0d not checked (now cycle %0d)",
                 e.name, k, e.cyc, cyc);
      end else if (((uo[k] & e.m_uo) !== e.e_uo) || ((uio_o[k] & e.m_uio) !== e.e_uio) ||
                   ((oe[k] & e.m_oe) !== e.e_oe)) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got uo_out=%h uio_out=%h uio_oe=%h, want (masked %h/%h/%h) %h/%h/%h",
                 e.name, k, cyc, uo[k], uio_o[k], oe[k], e.m_uo, e.m_uio, e.m_oe,
                 e.e_uo, e.e_uio, e.e_oe);
      end
    end
  endtask

  // Cycle count: number of rising edges since reset release.
  always @(posedge clk) begin
    if (run) cyc <= cyc + 1;
  end

  // Monitor: clocked expectations on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) check_front(k, 1'b0);
  end

  // Monitor: expectations that must hold between clock edges.
  always @(async_ev) begin
    for (int k = 0; k < 4; k++) check_front(k, 1'b1);
  end

  // Stimulus and expectation tables.
  initial begin
    rst_n = 1'b0; rst_n_d = 1'b0; ena_on = 1'b1; ena_d = 1'b1;
    ui[0] = 8'h00; uio_i[0] = 8'h00;   // alarm 00:00
    ui[1] = 8'h20; uio_i[1] = 8'h00;   // alarm 00:01
    ui[2] = 8'h98; uio_i[2] = 8'h07;   // alarm 24:60, unreachable
    ui[3] = 8'h01; uio_i[3] = 8'h00;   // alarm 01:00, idle here

    for (int k = 0; k < 4; k++)
      push(k, 0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hF8, "reset_release");

    // dut0, one second per two clocks
    push(0, 1,    1'b0, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, "alarm_0000_rise");
    push(0, 2,    1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, "blink_high");
    push(0, 4,    1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "blink_low");
    push(0, 120,  1'b0, 8'h7F, 8'h41, 8'hF8, 8'h00, 8'h00, 8'h00, "minute_carry");
    push(0, 121,  1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "alarm_0000_fall");
    push(0, 7200, 1'b0, 8'h3F, 8'h00, 8'hF8, 8'h08, 8'hFF, 8'hF8, "hour_carry");

    // dut1, one second per clock, alarm 00:01
    for (int c = 1; c <= 130; c++)
      push(1, c, 1'b0, 8'h40, (c >= 61 && c <= 120) ? 8'h40 : 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, "alarm_window");
    push(1, 86399, 1'b0, 8'hFF, 8'hBB, 8'hFF, 8'hB8, 8'hFF, 8'hF8, "day_235959");
    push(1, 86400, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hF8, "day_wrap");

    // dut2, out-of-range alarm must never fire
    for (int c = 1; c <= 86400; c++)
      push(2, c, 1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "invalid_alarm");

    // dut3, ena held low over edges 6..15
    for (int c = 5; c <= 15; c++)
      push(3, c, 1'b0, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, "ena_hold_000005");
    push(3, 16, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, "ena_resume_000006");
    push(3, 17, 1'b0, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, "ena_resume_000007");
    push(3, 17, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hF8, "async_reset");

    #12;
    rst_n = 1'b1; rst_n_d = 1'b1; run = 1'b1;
    #1 -> async_ev;

    wait (cyc == 5);
    @(negedge clk);
    ena_d = 1'b0;
    wait (cyc == 15);
    @(negedge clk);
    ena_d = 1'b1;
    wait (cyc == 17);
    @(negedge clk);
    #1 rst_n_d = 1'b0;
    #1 -> async_ev;

    wait (cyc == LAST_CYC);
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      while (sbq[k].size() > 0) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: expectation for cycle %0d never checked",
                 sbq[k][0].name, k, sbq[k][0].cyc);
        void'(sbq[k].pop_front());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach cycle %0d (at cycle %0d)", LAST_CYC, cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
